mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Handshake and memory-bus signals between the fetch/data requesters, the arbiter
// and the shared memory. The arbiter uses the slave view; requesters and memory use master.
interface mem_arbiter_if;
  logic        if_req;
  logic [5:0]  if_addr;
  logic        if_ready;
  logic [15:0] if_inst;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_addr;
  logic [15:0] d_wdata;
  logic        d_ready;
  logic [15:0] d_rdata;
  logic        if_stall;
  logic        d_stall;
  logic        m_en;
  logic        m_sel;
  logic        m_we;
  logic [5:0]  m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output if_ready, if_inst, d_ready, d_rdata, if_stall, d_stall,
    output m_en, m_sel, m_we, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  if_ready, if_inst, d_ready, d_rdata, if_stall, d_stall,
    input  m_en, m_sel, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch and data access.
// Data wins by default; fetch is forced through after three data grants in a row.
module mem_arbiter #(
  parameter int unsigned LAT = 2
) (
  input logic          clk,
  input logic          clear,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  localparam logic [2:0] CntInit = 3'(LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  starve_q, starve_d;
  logic        sel_q, sel_d;
  logic        we_q, we_d;
  logic [5:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] if_inst_q, if_inst_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        fetch_win;
  logic        busy;
  logic        resp;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    sel_d     = sel_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if_inst_d = if_inst_q;
    d_rdata_d = d_rdata_q;
    fetch_win = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.d_req || bus.if_req) begin
          // Fetch only beats a pending data request once starvation saturates.
          fetch_win = bus.if_req && (!bus.d_req || (starve_q == 2'd3));
          if (fetch_win) begin
            sel_d    = 1'b0;
            addr_d   = bus.if_addr;
            we_d     = 1'b0;
            wdata_d  = '0;
            starve_d = '0;
          end else begin
            sel_d    = 1'b1;
            addr_d   = {2'b00, bus.d_addr};
            we_d     = bus.d_we;
            wdata_d  = bus.d_wdata;
            starve_d = bus.if_req ? starve_q + 2'd1 : 2'd0;
          end
          cnt_d   = CntInit;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == 3'd0) begin
          state_d = StResp;
          if (!sel_q) begin
            if_inst_d = bus.m_rdata;
          end else if (!we_q) begin
            d_rdata_d = bus.m_rdata;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      starve_q  <= '0;
      sel_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      if_inst_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      if_inst_q <= if_inst_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign busy = (state_q == StBusy);
  assign resp = (state_q == StResp);

  // The memory bus is driven only while an access is in flight; it is quiet otherwise.
  assign bus.m_en    = busy;
  assign bus.m_sel   = busy & sel_q;
  assign bus.m_we    = busy & we_q;
  assign bus.m_addr  = busy ? addr_q : 6'd0;
  assign bus.m_wdata = busy ? wdata_q : 16'd0;

  assign bus.if_ready = resp & ~sel_q;
  assign bus.d_ready  = resp & sel_q;
  assign bus.if_inst  = if_inst_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.if_stall = bus.if_req & ~bus.if_ready;
  assign bus.d_stall  = bus.d_req & ~bus.d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one LAT=2 instance for most scenarios and a
// LAT=1 instance for the back-to-back fetch cadence.
module tb_mem_arbiter;

  logic clk;
  logic clear;
  int   n_assert;
  int   n_fail;

  mem_arbiter_if bus0 ();
  mem_arbiter_if bus1 ();

  mem_arbiter #(.LAT(2)) u_dut2 (
    .clk   (clk),
    .clear (clear),
    .bus   (bus0.slave)
  );

  mem_arbiter #(.LAT(1)) u_dut1 (
    .clk   (clk),
    .clear (clear),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] seq;
    n_assert = 0;
    n_fail   = 0;
    seq      = 8'b0111_0111;  // bit i = expected m_sel of grant i (1 = data)

    bus0.if_req = 0; bus0.if_addr = 0; bus0.d_req = 0; bus0.d_we = 0;
    bus0.d_addr = 0; bus0.d_wdata = 0; bus0.m_rdata = 0;
    bus1.if_req = 0; bus1.if_addr = 0; bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_addr = 0; bus1.d_wdata = 0; bus1.m_rdata = 0;

    // Reset: a pending fetch must not be granted while clear is high.
    clear       = 1;
    bus0.if_req = 1;
    tick();
    tick();
    chk("rst_m_en", bus0.m_en, 0);
    chk("rst_m_addr", bus0.m_addr, 0);
    chk("rst_if_ready", bus0.if_ready, 0);
    chk("rst_d_ready", bus0.d_ready, 0);
    chk("rst_if_inst", bus0.if_inst, 0);
    chk("rst_d_rdata", bus0.d_rdata, 0);
    chk("rst_if_stall", bus0.if_stall, 1);
    chk("rst_d_stall", bus0.d_stall, 0);
    bus0.if_req = 0;
    clear       = 0;
    tick();

    // Single fetch, LAT=2.
    bus0.if_req  = 1;
    bus0.if_addr = 5;
    bus0.m_rdata = 16'h2123;
    tick();
    chk("f_c1_m_en", bus0.m_en, 1);
    chk("f_c1_m_sel", bus0.m_sel, 0);
    chk("f_c1_m_addr", bus0.m_addr, 5);
    chk("f_c1_if_stall", bus0.if_stall, 1);
    tick();
    chk("f_c2_m_en", bus0.m_en, 1);
    chk("f_c2_m_addr", bus0.m_addr, 5);
    tick();
    chk("f_c3_if_ready", bus0.if_ready, 1);
    chk("f_c3_if_inst", bus0.if_inst, 16'h2123);
    chk("f_c3_m_en", bus0.m_en, 0);
    chk("f_c3_if_stall", bus0.if_stall, 0);
    bus0.if_req = 0;
    tick();
    chk("f_c4_if_ready", bus0.if_ready, 0);
    chk("f_c4_if_inst", bus0.if_inst, 16'h2123);

    // Simultaneous data read and fetch: data first, fetch follows.
    bus0.d_req   = 1;
    bus0.d_we    = 0;
    bus0.d_addr  = 3;
    bus0.if_req  = 1;
    bus0.if_addr = 7;
    bus0.m_rdata = 16'h0042;
    tick();
    chk("df_c1_m_sel", bus0.m_sel, 1);
    chk("df_c1_m_addr", bus0.m_addr, 3);
    chk("df_c1_if_stall", bus0.if_stall, 1);
    tick();
    tick();
    chk("df_c3_d_ready", bus0.d_ready, 1);
    chk("df_c3_if_ready", bus0.if_ready, 0);
    chk("df_c3_d_rdata", bus0.d_rdata, 16'h0042);
    chk("df_c3_if_stall", bus0.if_stall, 1);
    bus0.d_req   = 0;
    bus0.m_rdata = 16'h1357;
    tick();
    chk("df_c4_m_en", bus0.m_en, 0);
    chk("df_c4_if_stall", bus0.if_stall, 1);
    tick();
    chk("df_c5_m_en", bus0.m_en, 1);
    chk("df_c5_m_sel", bus0.m_sel, 0);
    chk("df_c5_m_addr", bus0.m_addr, 7);
    tick();
    chk("df_c6_if_stall", bus0.if_stall, 1);
    tick();
    chk("df_c7_if_ready", bus0.if_ready, 1);
    chk("df_c7_if_inst", bus0.if_inst, 16'h1357);
    chk("df_c7_d_rdata", bus0.d_rdata, 16'h0042);
    bus0.if_req = 0;
    tick();

    // Write; inputs change mid-access and memory returns junk that must be ignored.
    bus0.d_req   = 1;
    bus0.d_we    = 1;
    bus0.d_addr  = 9;
    bus0.d_wdata = 16'hBEEF;
    bus0.m_rdata = 16'hDEAD;
    tick();
    chk("w_c1_m_we", bus0.m_we, 1);
    chk("w_c1_m_addr", bus0.m_addr, 9);
    chk("w_c1_m_wdata", bus0.m_wdata, 16'hBEEF);
    bus0.d_addr  = 0;
    bus0.d_wdata = 0;
    bus0.d_we    = 0;
    tick();
    chk("w_c2_m_we", bus0.m_we, 1);
    chk("w_c2_m_addr", bus0.m_addr, 9);
    chk("w_c2_m_wdata", bus0.m_wdata, 16'hBEEF);
    tick();
    chk("w_c3_d_ready", bus0.d_ready, 1);
    chk("w_c3_m_we", bus0.m_we, 0);
    chk("w_c3_m_wdata", bus0.m_wdata, 0);
    chk("w_c3_d_rdata", bus0.d_rdata, 16'h0042);
    bus0.d_req = 0;
    tick();

    // Both requesters held: starvation guard lets every fourth grant go to fetch.
    bus0.d_req   = 1;
    bus0.d_we    = 0;
    bus0.d_addr  = 1;
    bus0.if_req  = 1;
    bus0.if_addr = 2;
    bus0.m_rdata = 16'h0F0F;
    for (int g = 0; g < 8; g++) begin
      tick();
      chk($sformatf("starve_g%0d_sel", g), bus0.m_sel, seq[g]);
      tick();
      tick();
      chk($sformatf("starve_g%0d_d_ready", g), bus0.d_ready, seq[g]);
      chk($sformatf("starve_g%0d_if_ready", g), bus0.if_ready, !seq[g]);
      tick();
    end
    bus0.d_req  = 0;
    bus0.if_req = 0;
    tick();
    chk("starve_end_m_en", bus0.m_en, 0);

    // Clear in the middle of a fetch aborts it; a fresh fetch then proceeds normally.
    bus0.if_req  = 1;
    bus0.if_addr = 12;
    bus0.m_rdata = 16'hAAAA;
    tick();
    chk("clr_c1_m_en", bus0.m_en, 1);
    clear = 1;
    tick();
    chk("clr_c2_m_en", bus0.m_en, 0);
    chk("clr_c2_if_ready", bus0.if_ready, 0);
    chk("clr_c2_if_inst", bus0.if_inst, 0);
    chk("clr_c2_d_rdata", bus0.d_rdata, 0);
    chk("clr_c2_if_stall", bus0.if_stall, 1);
    clear = 0;
    tick();
    chk("clr_c3_m_en", bus0.m_en, 1);
    chk("clr_c3_m_addr", bus0.m_addr, 12);
    chk("clr_c3_if_ready", bus0.if_ready, 0);
    tick();
    tick();
    chk("clr_c5_if_ready", bus0.if_ready, 1);
    chk("clr_c5_if_inst", bus0.if_inst, 16'hAAAA);
    bus0.if_req = 0;
    tick();

    // LAT=1 instance: fetch held high gives a three-cycle cadence.
    bus1.if_req  = 1;
    bus1.if_addr = 2;
    bus1.m_rdata = 16'h0303;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk($sformatf("lat1_c%0d_m_en", c), bus1.m_en, (c % 3) == 1);
      chk($sformatf("lat1_c%0d_if_ready", c), bus1.if_ready, (c % 3) == 2);
      if (c == 2) chk("lat1_c2_if_inst", bus1.if_inst, 16'h0303);
    end
    bus1.if_req = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
